// File: rtl/mult_job_sequencer.sv
// mult_job_sequencer: drives multiply/popcount peripheral bus cycles per operand pair and streams results
module mult_job_sequencer #(
  parameter int STB_LEN  = 2,
  parameter int POLL_GAP = 4,
  parameter int POLL_MAX = 64
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_a,
  input  logic [23:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_w,
  output logic [5:0]  out_ones,
  output logic        out_err,
  output logic [15:0] saddress,
  output logic        srd,
  output logic        swr,
  output logic [31:0] sdata_wr,
  input  logic [31:0] sdata_rd,
  output logic        busy,
  output logic [15:0] job_count
);
  localparam int CW = $clog2(STB_LEN + 1);
  localparam int GW = $clog2(POLL_GAP + 2);
  localparam int PW = $clog2(POLL_MAX + 1);
  typedef enum logic [3:0] {IDLE, WR_A1, WR_A2, WR_GO, RD_STAT, WAIT, RD_W, RD_L, OUT} state_t;
  typedef enum logic [1:0] {SETUP, STRB, HOLD} phase_t;
  state_t        state;
  phase_t        ph;
  logic [CW-1:0] cnt;
  logic [GW-1:0] gap;
  logic [PW-1:0] poll;
  logic [23:0]   b_q;
  logic          on_bus, is_rd;
  always_comb begin
    on_bus = !(state inside {IDLE, WAIT, OUT});
    is_rd  = state inside {RD_STAT, RD_W, RD_L};
  end
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state     <= IDLE;
      ph        <= SETUP;
      cnt       <= '0;
      gap       <= '0;
      poll      <= '0;
      b_q       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_w     <= '0;
      out_ones  <= '0;
      out_err   <= 1'b0;
      saddress  <= '0;
      srd       <= 1'b0;
      swr       <= 1'b0;
      sdata_wr  <= '0;
      busy      <= 1'b0;
      job_count <= '0;
    end else begin
      // shared SETUP/STRB sequencing; each state only decides what follows its HOLD
      if (on_bus && ph == SETUP) begin
        ph  <= STRB;
        cnt <= '0;
        srd <= is_rd;
        swr <= !is_rd;
      end
      if (on_bus && ph == STRB) begin
        cnt <= cnt + 1'b1;
        if (cnt == CW'(STB_LEN - 1)) begin
          ph  <= HOLD;
          srd <= 1'b0;
          swr <= 1'b0;
        end
      end
      case (state)
        IDLE: if (in_valid) begin
          b_q      <= in_b;
          in_ready <= 1'b0;
          busy     <= 1'b1;
          out_err  <= 1'b0;
          state    <= WR_A1;
          ph       <= SETUP;
          saddress <= 16'h0380;
          sdata_wr <= {8'h0, in_a};
        end
        WR_A1: if (ph == HOLD) begin
          state    <= WR_A2;
          ph       <= SETUP;
          saddress <= 16'h0388;
          sdata_wr <= {8'h0, b_q};
        end
        WR_A2: if (ph == HOLD) begin
          state    <= WR_GO;
          ph       <= SETUP;
          saddress <= 16'h03A0;
          sdata_wr <= '0;
        end
        WR_GO: if (ph == HOLD) begin
          state <= RD_STAT;
          ph    <= SETUP;
          poll  <= '0;
        end
        RD_STAT: if (ph == HOLD) begin
          poll <= poll + 1'b1;
          if (sdata_rd[1:0] == 2'b11) begin
            state    <= RD_W;
            ph       <= SETUP;
            saddress <= 16'h0390;
          end else if (poll + 1'b1 == PW'(POLL_MAX)) begin
            state     <= OUT;
            out_err   <= 1'b1;
            out_w     <= '0;
            out_ones  <= '0;
            out_valid <= 1'b1;
            busy      <= 1'b0;
          end else if (POLL_GAP == 0) begin
            ph <= SETUP;
          end else begin
            state <= WAIT;
            gap   <= '0;
          end
        end
        WAIT: begin
          gap <= gap + 1'b1;
          if (gap == GW'(POLL_GAP - 1)) begin
            state <= RD_STAT;
            ph    <= SETUP;
          end
        end
        RD_W: if (ph == HOLD) begin
          out_w    <= sdata_rd;
          state    <= RD_L;
          ph       <= SETUP;
          saddress <= 16'h0398;
        end
        RD_L: if (ph == HOLD) begin
          out_ones  <= sdata_rd[5:0];
          out_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= OUT;
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          job_count <= job_count + 1'b1;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_job_sequencer.sv
// tb_mult_job_sequencer: scoreboard bench with a peripheral bus model and bus protocol checker
module tb_mult_job_sequencer;
  localparam int STB_LEN = 2, POLL_GAP = 4, POLL_MAX = 64;
  logic clk = 0, n_reset = 0, in_valid = 0, out_ready = 1;
  logic [23:0] in_a = 0, in_b = 0;
  logic        in_ready, out_valid, out_err, srd, swr, busy;
  logic [31:0] out_w, sdata_wr, sdata_rd;
  logic [5:0]  out_ones;
  logic [15:0] saddress, job_count;

  mult_job_sequencer #(.STB_LEN(STB_LEN), .POLL_GAP(POLL_GAP), .POLL_MAX(POLL_MAX)) dut (
    .clk(clk), .n_reset(n_reset), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_w(out_w), .out_ones(out_ones), .out_err(out_err),
    .saddress(saddress), .srd(srd), .swr(swr), .sdata_wr(sdata_wr), .sdata_rd(sdata_rd),
    .busy(busy), .job_count(job_count));

  always #5 clk = ~clk;

  typedef struct {logic [31:0] w; logic [5:0] ones; logic err; int lat;} exp_t;
  typedef struct {logic rd; logic [15:0] addr; logic [31:0] data; int cyc;} bus_t;
  exp_t exp_q[$];
  int   acc_q[$];
  bus_t blog[$];
  int   checks = 0, passes = 0, cyc = 0, viol = 0;
  int   done_on = 1, polls = 0;
  logic [23:0] r_a1 = 0, r_a2 = 0;
  logic [47:0] prod;

  // peripheral model: status reports done once the done_on-th poll since GO is reached
  assign prod = {24'h0, r_a1} * {24'h0, r_a2};
  assign sdata_rd = saddress == 16'h03A0 ? {30'h0, (done_on != 0 && polls >= done_on) ? 2'b11 : 2'b01} :
                    saddress == 16'h0390 ? prod[31:0] :
                    saddress == 16'h0398 ? {26'h3FFFFFF, 6'($countones(prod[31:0]))} : 32'hDEADBEEF;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
  endtask

  task automatic push_exp(input logic [31:0] w, input logic [5:0] ones, input logic err, input int lat);
    exp_q.push_back('{w, ones, err, lat});
  endtask

  task automatic send(input logic [23:0] a, input logic [23:0] b, input bit drop);
    int t = 0;
    @(posedge clk); #1;
    in_a = a; in_b = b; in_valid = 1;
    @(negedge clk);
    while (!in_ready && t < 2000) begin @(negedge clk); t++; end
    if (!in_ready) begin checks++; $display("FAIL accept_timeout: got in_ready=0 expected 1"); end
    @(posedge clk); #1;
    if (drop) in_valid = 0;
  endtask

  task automatic wait_jobs(input int n);
    int t = 0;
    while (job_count != 16'(n) && t < 3000) begin @(negedge clk); t++; end
    chk("job_count", 32'(job_count), 32'(n));
  endtask

  // scoreboard monitor
  logic prev_ov = 0;
  int   a_t;
  exp_t e;
  always @(negedge clk) begin
    cyc++;
    if (!n_reset) begin
      acc_q.delete();
      prev_ov = 0;
    end else begin
      if (in_valid && in_ready) acc_q.push_back(cyc);
      if (out_valid && !prev_ov && exp_q.size() > 0 && acc_q.size() > 0) begin
        a_t = acc_q.pop_front();
        if (exp_q[0].lat != 0) chk("latency", 32'(cyc - a_t), 32'(exp_q[0].lat));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_output: got w=0x%0h with no job pending", out_w);
        end else begin
          e = exp_q.pop_front();
          chk("out_w", out_w, e.w);
          chk("out_ones", 32'(out_ones), 32'(e.ones));
          chk("out_err", 32'(out_err), 32'(e.err));
        end
      end
      prev_ov = out_valid;
    end
  end

  // bus protocol checker, transaction log and peripheral register updates
  logic        prev_s = 0, s;
  logic [15:0] prev_addr = 0, paddr = 0;
  logic [31:0] pdata = 0;
  int          plen = 0, low_run = 2;
  always @(negedge clk) begin
    s = srd | swr;
    if (!n_reset) begin
      low_run = 2;
      s = 0;
    end else begin
      if (srd && swr) viol++;
      if (s && !prev_s) begin
        if (low_run < 2 || saddress !== prev_addr) viol++;
        plen = 1; paddr = saddress; pdata = sdata_wr;
        blog.push_back('{srd, saddress, sdata_wr, cyc});
        if (swr && saddress == 16'h0380) r_a1 = sdata_wr[23:0];
        if (swr && saddress == 16'h0388) r_a2 = sdata_wr[23:0];
        if (swr && saddress == 16'h03A0) polls = 0;
        if (srd && saddress == 16'h03A0) polls++;
      end else if (s) begin
        plen++;
        if (saddress !== paddr || (swr && sdata_wr !== pdata)) viol++;
      end else if (prev_s) begin
        if (plen != STB_LEN || saddress !== paddr) viol++;
      end
      low_run = s ? 0 : low_run + 1;
    end
    prev_s = s;
    prev_addr = saddress;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  int base, n, bad, last;
  logic [31:0] w0;
  logic [5:0]  o0;
  logic        e0;
  logic [23:0] t6a [3] = '{24'h2, 24'h1000, 24'hABCD};
  logic [23:0] t6b [3] = '{24'h7, 24'h1000, 24'h10};
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_strobes", 32'({srd, swr}), 0);
    chk("rst_saddress", 32'(saddress), 0);
    chk("rst_job_count", 32'(job_count), 0);
    chk("rst_out_err", 32'(out_err), 0);
    @(posedge clk); #1 n_reset = 1;

    base = blog.size();
    push_exp(32'd15, 6'd4, 1'b0, 25);
    send(24'd3, 24'd5, 1);
    wait_jobs(1);
    chk("t1_accesses", 32'(blog.size() - base), 6);
    if (blog.size() >= base + 3) begin
      chk("t1_a1_addr", 32'(blog[base].addr), 32'h0380);
      chk("t1_a1_data", blog[base].data, 3);
      chk("t1_a2_addr", 32'(blog[base+1].addr), 32'h0388);
      chk("t1_a2_data", blog[base+1].data, 5);
      chk("t1_go", 32'({blog[base+2].rd, blog[base+2].addr}), 32'h03A0);
    end

    done_on = 0;
    base = blog.size();
    push_exp(32'd0, 6'd0, 1'b1, 0);
    send(24'h123, 24'h456, 1);
    wait_jobs(2);
    n = 0; bad = 0; last = -1;
    for (int i = base; i < blog.size(); i++)
      if (blog[i].rd && blog[i].addr == 16'h03A0) begin
        n++;
        if (last >= 0 && blog[i].cyc - last != STB_LEN + 2 + POLL_GAP) bad++;
        last = blog[i].cyc;
      end
    chk("t3_poll_count", 32'(n), POLL_MAX);
    chk("t3_poll_spacing", 32'(bad), 0);

    done_on = 3;
    base = blog.size();
    push_exp(32'hFE000001, 6'd8, 1'b0, 0);
    send(24'hFFFFFF, 24'hFFFFFF, 1);
    wait_jobs(3);
    chk("t2_accesses", 32'(blog.size() - base), 8);
    if (blog.size() > base) chk("t2_a1_data", blog[base].data, 32'h00FFFFFF);
    chk("t2_bus_protocol", 32'(viol), 0);

    done_on = 1;
    out_ready = 0;
    push_exp(32'd42, 6'd3, 1'b0, 25);
    send(24'd6, 24'd7, 1);
    n = 0;
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    chk("t4_valid_seen", 32'(out_valid), 1);
    w0 = out_w; o0 = out_ones; e0 = out_err; bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!out_valid || out_w !== w0 || out_ones !== o0 || out_err !== e0 || in_ready || srd || swr || busy) bad++;
    end
    chk("t4_stall_stable", 32'(bad), 0);
    @(posedge clk); #1 out_ready = 1;
    @(negedge clk);
    @(negedge clk);
    chk("t4_in_ready", 32'(in_ready), 1);
    chk("t4_out_valid", 32'(out_valid), 0);
    chk("t4_job_count", 32'(job_count), 4);

    send(24'd9, 24'd9, 1);
    n = 0;
    while (!(swr && saddress == 16'h0388) && n < 200) begin @(negedge clk); n++; end
    chk("t5_in_strobe", 32'(swr), 1);
    n_reset = 0;
    #1;
    chk("t5_swr", 32'(swr), 0);
    chk("t5_in_ready", 32'(in_ready), 1);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_saddress", 32'(saddress), 0);
    chk("t5_sdata_wr", sdata_wr, 0);
    chk("t5_job_count", 32'(job_count), 0);
    chk("t5_out_w", out_w, 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 n_reset = 1;

    base = blog.size();
    push_exp(32'd14, 6'd3, 1'b0, 25);
    push_exp(32'h01000000, 6'd1, 1'b0, 25);
    push_exp(32'h000ABCD0, 6'd10, 1'b0, 25);
    send(t6a[0], t6b[0], 0);
    send(t6a[1], t6b[1], 0);
    send(t6a[2], t6b[2], 1);
    wait_jobs(3);
    chk("t6_accesses", 32'(blog.size() - base), 18);
    if (blog.size() >= base + 18)
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("t6_a1_%0d", k), blog[base+6*k].data, {8'h0, t6a[k]});
        chk($sformatf("t6_a2_%0d", k), blog[base+6*k+1].data, {8'h0, t6b[k]});
        chk($sformatf("t6_go_%0d", k), 32'(blog[base+6*k+2].addr), 32'h03A0);
      end

    repeat (5) @(negedge clk);
    chk("bus_protocol", 32'(viol), 0);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
